// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-state decoder: prefix bytes,
// prefix FSM states, default key map and the event record.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;
   localparam logic [7:0] PS2_BAT   = 8'hAA;

   // Bytes remaining in a Pause sequence once its leading E1 is consumed.
   localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

   // Event key field is sized for the largest supported map (32 keys).
   localparam int unsigned PS2_KEY_W = 5;

   // Entry i = {ext, code}; keys 0..7 = W X C V B N , ;
   localparam logic [71:0] PS2_DEFAULT_KEYMAP = {
      9'h04C, 9'h041, 9'h031, 9'h032, 9'h02A, 9'h021, 9'h022, 9'h01D
   };

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXTBRK,
      S_SKIP
   } ps2_state_t;

   typedef struct packed {
      logic [PS2_KEY_W-1:0] key;
      logic                 pressed;
   } ps2_evt_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// Generic synchronous FIFO with extra-MSB wrap pointers. A push while full is
// accepted only when a pop frees the head slot in the same cycle.
module kbd_event_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_wr_en;
   logic             w_rd_en;

   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_wr_en = push && (!full || pop);
   assign w_rd_en = pop && !empty;
   assign dout    = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 key-state decoder: prefix FSM, key-map lookup, level
// bitmap and press/release event FIFO. Optional prefix watchdog: PS2_WATCHDOG_EN.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned           NUM_KEYS       = 8,
   parameter int unsigned           FIFO_DEPTH     = 4,
   parameter logic [NUM_KEYS*9-1:0] KEYMAP         = PS2_DEFAULT_KEYMAP,
   parameter int unsigned           TIMEOUT_CYCLES = 1048576,
   localparam int unsigned          KW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   input  logic                rx_error,
   output logic [NUM_KEYS-1:0] keys,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [KW-1:0]       evt_key,
   output logic                evt_pressed,
   output logic                evt_overflow,
   input  logic                ovf_clr
);

   ps2_state_t           r_state;
   ps2_state_t           w_state_nxt;
   logic [2:0]           r_cnt;
   logic [2:0]           w_cnt_nxt;
   logic [NUM_KEYS-1:0]  r_keys;
   logic                 r_ovf;

   logic                 w_dec_en;
   logic                 w_dec_ext;
   logic                 w_dec_make;
   logic                 w_bat;
   logic                 w_wdt_expire;

   logic [8:0]           w_code;
   logic [NUM_KEYS-1:0]  w_hit_mask;
   logic [PS2_KEY_W-1:0] w_hit_idx;
   logic                 w_found;
   logic                 w_was_held;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_drop;
   ps2_evt_t             w_evt_in;
   ps2_evt_t             w_head;
   logic                 w_unused;

`ifdef PS2_WATCHDOG_EN
   logic [31:0]          r_wdt;

   assign w_wdt_expire = (r_state != S_IDLE) && (r_wdt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                r_wdt <= '0;
      else if (rx_valid || w_state_nxt == S_IDLE) r_wdt <= '0;
      else                                      r_wdt <= r_wdt + 32'd1;
   end
`else
   assign w_wdt_expire = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // rx_error outranks a same-cycle byte; the watchdog only acts on idle cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dec_en    = 1'b0;
      w_dec_ext   = 1'b0;
      w_dec_make  = 1'b0;
      w_bat       = 1'b0;
      if (rx_error) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else if (rx_valid) begin
         unique case (r_state)
            S_IDLE: begin
               if (rx_data == PS2_EXT) begin
                  w_state_nxt = S_EXT;
               end else if (rx_data == PS2_BRK) begin
                  w_state_nxt = S_BRK;
               end else if (rx_data == PS2_PAUSE) begin
                  w_state_nxt = S_SKIP;
                  w_cnt_nxt   = PS2_PAUSE_TAIL;
               end else if (rx_data == PS2_BAT) begin
                  w_bat = 1'b1;
               end else begin
                  w_dec_en   = 1'b1;
                  w_dec_make = 1'b1;
               end
            end
            S_EXT: begin
               if (rx_data == PS2_BRK) begin
                  w_state_nxt = S_EXTBRK;
               end else if (rx_data != PS2_EXT) begin
                  w_dec_en    = 1'b1;
                  w_dec_ext   = 1'b1;
                  w_dec_make  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_BRK: begin
               w_dec_en    = 1'b1;
               w_state_nxt = S_IDLE;
            end
            S_EXTBRK: begin
               w_dec_en    = 1'b1;
               w_dec_ext   = 1'b1;
               w_state_nxt = S_IDLE;
            end
            S_SKIP: begin
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt == 3'd1) w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end else if (w_wdt_expire) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end
   end

   assign w_code = {w_dec_ext, rx_data};

   // First match wins, so duplicated map entries resolve to the lowest index.
   always_comb begin
      w_hit_mask = '0;
      w_hit_idx  = '0;
      w_found    = 1'b0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
         if (!w_found && KEYMAP[i*9 +: 9] == w_code) begin
            w_found       = 1'b1;
            w_hit_mask[i] = 1'b1;
            w_hit_idx     = PS2_KEY_W'(i);
         end
      end
   end

   assign w_was_held = |(r_keys & w_hit_mask);
   assign w_push     = w_dec_en && w_found && (w_dec_make ? !w_was_held : w_was_held);
   assign w_pop      = !w_empty && evt_ready;
   assign w_drop     = w_push && w_full && !w_pop;
   assign w_evt_in   = '{key: w_hit_idx, pressed: w_dec_make};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_keys <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_bat)         r_keys <= '0;
         else if (w_dec_en) r_keys <= w_dec_make ? (r_keys | w_hit_mask) : (r_keys & ~w_hit_mask);
         if (w_drop)        r_ovf <= 1'b1;
         else if (ovf_clr)  r_ovf <= 1'b0;
      end
   end

   kbd_event_fifo #(
      .WIDTH ($bits(ps2_evt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (w_evt_in),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   assign keys         = r_keys;
   assign evt_valid    = !w_empty;
   assign evt_key      = w_head.key[KW-1:0];
   assign evt_pressed  = w_head.pressed;
   assign evt_overflow = r_ovf;
   assign w_unused     = ^{w_head.key, TIMEOUT_CYCLES};

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised successor to the fixed 8-key PS/2 key-state decoder.
- Consumes the byte stream from the PS/2 byte receiver and decodes make, break, E0-extended and E1 (Pause) sequences.
- Drives a level bitmap of NUM_KEYS mapped keys and pushes press/release events into a small FIFO with a valid/ready handshake.
- Sits between the PS/2 receiver and the game/CPU input logic.

Parameters:
- NUM_KEYS, 8: number of mapped keys; range 1..32.
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, at least 2.
- KEYMAP, {9'h04C,9'h041,9'h031,9'h032,9'h02A,9'h021,9'h022,9'h01D}: flattened NUM_KEYS×9 bits. Entry i is {ext, code}; ext=1 means the key requires the E0 prefix. The default maps W X C V B N , ; to keys 0..7.
- TIMEOUT_CYCLES, 1048576: prefix watchdog limit in clk cycles. Used only with PS2_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received PS/2 byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
- rx_error  in  1  one-cycle strobe; parity/framing error from the receiver
- keys  out  NUM_KEYS  level state; bit i = 1 while key i is held
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts the head entry when evt_valid is also high
- evt_key  out  KW  key index of the head entry; KW = max(1, $clog2(NUM_KEYS))
- evt_pressed  out  1  head entry type: 1 = press, 0 = release
- evt_overflow  out  1  sticky flag: an event was dropped
- ovf_clr  in  1  clears evt_overflow

Behaviour:
Reset:
- Reset is asynchronous and active-high.
- Reset values: keys=0, FIFO empty (evt_valid=0), evt_key=0, evt_pressed=0, evt_overflow=0, FSM in IDLE, skip counter=0.

Prefix FSM (advances only on rx_valid):
- IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with cnt=7; any other byte -> decode {0,byte} as make, stay in IDLE.
- EXT: F0 -> EXTBRK; E0 -> stay in EXT; any other byte -> decode {1,byte} as make, go to IDLE.
- BRK: decode {0,byte} as break, go to IDLE.
- EXTBRK: decode {1,byte} as break, go to IDLE.
- SKIP: discard the byte; cnt -= 1; when cnt reaches 0, go to IDLE. A Pause sequence is 8 bytes and produces no event.
- rx_error in any state forces IDLE and clears cnt. If rx_error and rx_valid occur in the same cycle, the error wins and the byte is discarded.

Decode:
- Compare the 9-bit code against every KEYMAP entry. On duplicate entries, the lowest index wins.
- An unmapped code changes nothing and generates no event.
- Make on key i:
  - keys[i] <= 1 on the cycle after rx_valid.
  - An event {i, pressed=1} is pushed only if keys[i] was previously 0. Typematic repeats are suppressed.
- Break on key i:
  - keys[i] <= 0.
  - An event {i, pressed=0} is pushed only if keys[i] was previously 1.
- Byte 0xAA received in IDLE (keyboard BAT/hot-plug): keys <= 0 and no events are pushed.

FIFO:
- Latency: evt_valid rises 1 cycle after the rx_valid that completes the sequence.
- Head data (evt_key, evt_pressed) is stable while evt_valid=1 and evt_ready=0.
- Pop happens when evt_valid && evt_ready.
- Push while full:
  - With a pop in the same cycle: the push is accepted and the count is unchanged.
  - Without a pop: the new event is dropped and evt_overflow <= 1. keys is still updated.
- Push and pop when empty: no bypass. The event appears next cycle.
- ovf_clr clears evt_overflow. If a drop and ovf_clr occur in the same cycle, the flag stays set.
- Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the remaining bits are equal.

Optional Feature:
- Macro: PS2_WATCHDOG_EN.
- Defined:
  - A counter runs while the FSM is in EXT, BRK, EXTBRK or SKIP. It is cleared on every rx_valid and on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and cnt=0. This recovers from truncated sequences.
- Not defined: no counter is present, and the FSM can wait indefinitely in any prefix state.

Decomposition:
- Package ps2_pkg holds:
  - prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_BAT=8'hAA;
  - the FSM state enum;
  - the default KEYMAP constant;
  - the event struct {key, pressed}.
- Sub-module kbd_event_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty, and data out at the head.

Test Plan:
- Bytes 1D, then F0 1D -> keys=8'h01 one cycle after the first rx_valid, then keys=8'h00. FIFO contents: {0,1} then {0,0}.
- Bytes 1D 1D 1D (typematic) -> exactly one press event; keys[0]=1 throughout.
- Custom KEYMAP entry 3 = 9'h175 (extended Up). Bytes E0 75 -> keys[3]=1. Bytes 75 alone -> no change. Bytes E0 F0 75 -> keys[3]=0.
- FIFO_DEPTH=4, evt_ready=0, bytes for 5 distinct presses -> 4 events retained, evt_overflow=1. Pulse ovf_clr -> 0. Drain with evt_ready=1 -> events in order, evt_valid falls after the 4th pop.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> no keys change, no events, FSM back in IDLE. The next byte 22 sets keys[1].
- rx_error after E0, then 1D -> decoded as non-extended W (keys[0]=1). With PS2_WATCHDOG_EN and TIMEOUT_CYCLES=16: F0, idle 16 cycles, then 1D -> press event, not a release.
